// File: rtl/lr_fit.sv
// lr_fit: streaming least-squares line fit (y = slope*x + intercept) over a burst of
// signed fixed-point samples, solved with one shared sequential restoring divider.
module lr_fit #(
  parameter int DW    = 16,
  parameter int FRAC  = 8,
  parameter int MAX_N = 256,
  parameter int ACC_W = 64
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] in_x,
  input  logic signed [DW-1:0] in_y,
  input  logic                 in_last,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic signed [DW-1:0] slope,
  output logic signed [DW-1:0] intercept
);
  localparam int CNT_W = $clog2(ACC_W) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic signed [ACC_W-1:0] N_ONE  = ACC_W'(1);
  localparam logic signed [ACC_W-1:0] N_MAX  = ACC_W'(MAX_N);
  localparam logic signed [ACC_W-1:0] SAT_HI = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_LO = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_ACCUM, S_SOLVE, S_DIV_S, S_CALC_B, S_DIV_B, S_DONE
  } state_t;

  function automatic logic signed [DW-1:0] f_sat(input logic signed [ACC_W-1:0] v);
    if (v > SAT_HI)      return SAT_HI[DW-1:0];
    else if (v < SAT_LO) return SAT_LO[DW-1:0];
    else                 return v[DW-1:0];
  endfunction

  function automatic logic [ACC_W-1:0] f_abs(input logic signed [ACC_W-1:0] v);
    return v[ACC_W-1] ? -v : v;
  endfunction

  state_t                    r_state;
  logic signed [ACC_W-1:0]   r_n, r_sx, r_sy, r_sxy, r_sxx;
  logic [CNT_W-1:0]          r_cnt;
  logic                      r_done, r_err;
  logic signed [DW-1:0]      r_slope, r_icpt, r_slope_q;
  logic [ACC_W-1:0]          r_rem, r_quo, r_dvs;
  logic                      r_neg, r_den_zero;

  logic                      w_fire, w_first, w_last;
  logic signed [2*DW-1:0]    w_xy, w_xx;
  logic signed [ACC_W-1:0]   w_x_ext, w_y_ext, w_xy_ext, w_xx_ext, w_n_nxt;
  logic signed [ACC_W-1:0]   w_num, w_den, w_num_sh, w_q, w_slope_ext, w_t;
  logic signed [DW-1:0]      w_slope_sat;
  logic [ACC_W:0]            w_rem_sh, w_diff;

  // Accumulate stage: full-width products, sign-extended into the moment sums
  assign in_ready = (r_state == S_IDLE) || (r_state == S_ACCUM);
  assign busy     = (r_state != S_IDLE);
  assign w_fire   = in_valid && in_ready;
  assign w_first  = (r_state == S_IDLE);
  assign w_xy     = in_x * in_y;
  assign w_xx     = in_x * in_x;
  assign w_x_ext  = {{(ACC_W-DW){in_x[DW-1]}}, in_x};
  assign w_y_ext  = {{(ACC_W-DW){in_y[DW-1]}}, in_y};
  assign w_xy_ext = {{(ACC_W-2*DW){w_xy[2*DW-1]}}, w_xy};
  assign w_xx_ext = {{(ACC_W-2*DW){w_xx[2*DW-1]}}, w_xx};
  assign w_n_nxt  = w_first ? N_ONE : r_n + N_ONE;
  assign w_last   = in_last || (w_n_nxt == N_MAX);

  // Solve stage: closed-form numerator/denominator feed the divider directly
  assign w_num    = r_n * r_sxy - r_sx * r_sy;
  assign w_den    = r_n * r_sxx - r_sx * r_sx;
  assign w_num_sh = w_num <<< FRAC;

  // Divider: one restoring step per cycle on magnitudes, sign applied afterwards
  assign w_rem_sh    = {r_rem, r_quo[ACC_W-1]};
  assign w_diff      = w_rem_sh - {1'b0, r_dvs};
  assign w_q         = r_neg ? -$signed(r_quo) : $signed(r_quo);
  assign w_slope_sat = r_den_zero ? '0 : f_sat(w_q);
  assign w_slope_ext = {{(ACC_W-DW){w_slope_sat[DW-1]}}, w_slope_sat};
  assign w_t         = r_sy - ((w_slope_ext * r_sx) >>> FRAC);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_n     <= '0;
      r_sx    <= '0;
      r_sy    <= '0;
      r_sxy   <= '0;
      r_sxx   <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_slope <= '0;
      r_icpt  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE, S_ACCUM: begin
          if (w_fire) begin
            r_n     <= w_n_nxt;
            r_sx    <= (w_first ? '0 : r_sx)  + w_x_ext;
            r_sy    <= (w_first ? '0 : r_sy)  + w_y_ext;
            r_sxy   <= (w_first ? '0 : r_sxy) + w_xy_ext;
            r_sxx   <= (w_first ? '0 : r_sxx) + w_xx_ext;
            r_state <= w_last ? S_SOLVE : S_ACCUM;
          end
        end
        S_SOLVE: begin
          r_cnt   <= '0;
          r_state <= S_DIV_S;
        end
        S_DIV_S, S_DIV_B: begin
          r_cnt <= r_cnt + CNT_ONE;
          if (r_cnt == CNT_LAST)
            r_state <= (r_state == S_DIV_S) ? S_CALC_B : S_DONE;
        end
        S_CALC_B: begin
          r_cnt   <= '0;
          r_state <= S_DIV_B;
        end
        S_DONE: begin
          r_slope <= r_slope_q;
          r_icpt  <= f_sat(w_q);
          r_err   <= r_den_zero;
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Divider datapath: loaded in SOLVE (slope) and CALC_B (intercept)
  always_ff @(posedge CLK) begin
    case (r_state)
      S_SOLVE: begin
        r_rem      <= '0;
        r_quo      <= f_abs(w_num_sh);
        r_dvs      <= f_abs(w_den);
        r_neg      <= w_num_sh[ACC_W-1] ^ w_den[ACC_W-1];
        r_den_zero <= (w_den == '0);
      end
      S_CALC_B: begin
        r_rem     <= '0;
        r_quo     <= f_abs(w_t);
        r_dvs     <= f_abs(r_n);
        r_neg     <= w_t[ACC_W-1] ^ r_n[ACC_W-1];
        r_slope_q <= w_slope_sat;
      end
      S_DIV_S, S_DIV_B: begin
        if (!w_diff[ACC_W]) begin
          r_rem <= w_diff[ACC_W-1:0];
          r_quo <= {r_quo[ACC_W-2:0], 1'b1};
        end else begin
          r_rem <= w_rem_sh[ACC_W-1:0];
          r_quo <= {r_quo[ACC_W-2:0], 1'b0};
        end
      end
      default: ;
    endcase
  end

  assign done      = r_done;
  assign err       = r_err;
  assign slope     = r_slope;
  assign intercept = r_icpt;
endmodule

// File: tb/tb_lr_fit.sv
// Self-checking bench for lr_fit: scoreboard of expected fits, compared on each done pulse.
module tb_lr_fit;
  localparam int DW      = 16;
  localparam int FRAC    = 8;
  localparam int MAX_N   = 256;
  localparam int ACC_W   = 64;
  localparam int LAT_MAX = 3 * ACC_W + 16;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic in_valid = 1'b0;
  logic in_last = 1'b0;
  logic signed [DW-1:0] in_x = '0;
  logic signed [DW-1:0] in_y = '0;
  logic in_ready, busy, done, err;
  logic signed [DW-1:0] slope, intercept;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic signed [15:0] s;
    logic signed [15:0] b;
    logic               e;
    bit                 chk_b;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   bx[$];
  int   by[$];
  logic prev_done = 1'b0;

  lr_fit #(.DW(DW), .FRAC(FRAC), .MAX_N(MAX_N), .ACC_W(ACC_W)) dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_last(in_last), .busy(busy), .done(done),
    .err(err), .slope(slope), .intercept(intercept)
  );

  always #5 CLK = ~CLK;

  // Scoreboard: every done pulse pops and checks one expected fit
  always @(negedge CLK) begin
    if (done) begin
      checks++;
      if (prev_done) begin
        errors++;
        $display("FAIL done_pulse: done high on consecutive cycles (got 1, want 0)");
      end
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: done=1 with no burst expected");
      end else begin
        mon_e = sb.pop_front();
        if (slope !== mon_e.s || err !== mon_e.e || (mon_e.chk_b && intercept !== mon_e.b)) begin
          errors++;
          $display("FAIL fit_result: got slope=%h intercept=%h err=%b, want slope=%h intercept=%h err=%b (icpt checked=%0d)",
                   slope, intercept, err, mon_e.s, mon_e.b, mon_e.e, mon_e.chk_b);
        end
      end
    end
    prev_done = done;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  function automatic logic signed [15:0] sat16(input longint v);
    if (v > 32767)  return 16'sh7FFF;
    if (v < -32768) return 16'sh8000;
    return v[15:0];
  endfunction

  function automatic exp_t mk(input logic [15:0] s, input logic [15:0] b, input logic e, input bit cb);
    exp_t r;
    r.s = s; r.b = b; r.e = e; r.chk_b = cb;
    return r;
  endfunction

  function automatic exp_t model_fit();
    longint n, sx, sy, sxy, sxx, num, den, q, t;
    exp_t r;
    n = bx.size(); sx = 0; sy = 0; sxy = 0; sxx = 0;
    foreach (bx[i]) begin
      sx  += bx[i];
      sy  += by[i];
      sxy += longint'(bx[i]) * longint'(by[i]);
      sxx += longint'(bx[i]) * longint'(bx[i]);
    end
    num = n * sxy - sx * sy;
    den = n * sxx - sx * sx;
    r.chk_b = 1'b1;
    if (den == 0) begin
      r.e = 1'b1; r.s = 16'sh0000; r.b = sat16(sy / n);
    end else begin
      q   = (num <<< FRAC) / den;
      r.s = sat16(q);
      r.e = 1'b0;
      t   = sy - ((longint'(r.s) * sx) >>> FRAC);
      r.b = sat16(t / n);
    end
    return r;
  endfunction

  task automatic send_burst(input bit use_last);
    for (int i = 0; i < bx.size(); i++) begin
      in_valid = 1'b1;
      in_x     = DW'(bx[i]);
      in_y     = DW'(by[i]);
      in_last  = use_last && (i == bx.size() - 1);
      @(negedge CLK);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_drain(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge CLK);
      #1;
      if (sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    in_valid = 1'b0;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
    checks++; if (slope !== 16'h0000) begin errors++; $display("FAIL reset_slope: got %h want 0000", slope); end
    checks++; if (intercept !== 16'h0000) begin errors++; $display("FAIL reset_intercept: got %h want 0000", intercept); end
  endtask

  task automatic test_basic_fits();
    bit ok;
    bx = '{0, 256, 512};  by = '{256, 768, 1280};
    sb.push_back(mk(16'h0200, 16'h0100, 1'b0, 1'b1));
    send_burst(1'b1);
    wait_drain(400, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_rising_done: got no done, want done"); end
    bx = '{0, 512, 1024}; by = '{1024, 512, 0};
    sb.push_back(mk(16'hFF00, 16'h0400, 1'b0, 1'b1));
    send_burst(1'b1);
    wait_drain(400, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_falling_done: got no done, want done"); end
    bx = '{0, 256, 512};  by = '{0, 0, 256};
    sb.push_back(mk(16'h0080, 16'hFFD6, 1'b0, 1'b1));
    send_burst(1'b1);
    wait_drain(400, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_trunc_done: got no done, want done"); end
  endtask

  task automatic test_degenerate();
    bit ok;
    bx = '{256, 256}; by = '{512, 1024};
    sb.push_back(mk(16'h0000, 16'h0300, 1'b1, 1'b1));
    send_burst(1'b1);
    wait_drain(400, ok);
    checks++; if (!ok) begin errors++; $display("FAIL degen_equal_x_done: got no done, want done"); end
    bx = '{1280}; by = '{1792};
    sb.push_back(mk(16'h0000, 16'h0700, 1'b1, 1'b1));
    send_burst(1'b1);
    wait_drain(400, ok);
    checks++; if (!ok) begin errors++; $display("FAIL degen_single_done: got no done, want done"); end
  endtask

  task automatic test_hold_during_solve();
    int lat;
    bit bad_rdy, got, ok;
    bx = '{0, 256, 512}; by = '{256, 768, 1280};
    sb.push_back(mk(16'h0200, 16'h0100, 1'b0, 1'b1));
    send_burst(1'b1);
    in_valid = 1'b1; in_x = 16'sh1234; in_y = 16'sh0777; in_last = 1'b1;
    lat = 0; bad_rdy = 1'b0; got = 1'b0;
    while (lat < 400) begin
      if (lat < 20 && (in_ready !== 1'b0 || busy !== 1'b1)) bad_rdy = 1'b1;
      if (lat == 20) begin in_valid = 1'b0; in_last = 1'b0; end
      if (done) begin got = 1'b1; break; end
      @(negedge CLK);
      lat++;
    end
    in_valid = 1'b0; in_last = 1'b0;
    checks++; if (bad_rdy) begin errors++; $display("FAIL hold_ready: in_ready/busy wrong while solving, want in_ready=0 busy=1"); end
    checks++; if (!got) begin errors++; $display("FAIL hold_done: got no done in %0d cycles, want done", lat); end
    checks++; if (lat > LAT_MAX) begin errors++; $display("FAIL hold_latency: got %0d cycles, want <= %0d", lat, LAT_MAX); end
    wait_drain(10, ok);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hold_busy_after: got %b want 0", busy); end
  endtask

  task automatic test_max_n();
    bit ok;
    bx.delete(); by.delete();
    for (int i = 0; i < MAX_N; i++) begin
      bx.push_back(i);
      by.push_back(2 * i + 256);
    end
    sb.push_back(mk(16'h0200, 16'h0100, 1'b0, 1'b1));
    send_burst(1'b0);
    checks++; if (in_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL max_n_forced_last: got in_ready=%b busy=%b, want 0/1", in_ready, busy); end
    wait_drain(400, ok);
    checks++; if (!ok) begin errors++; $display("FAIL max_n_done: got no done, want done"); end
  endtask

  task automatic test_saturation();
    bit ok;
    bx = '{0, 1}; by = '{0, 32767};
    sb.push_back(mk(16'h7FFF, 16'h0000, 1'b0, 1'b0));
    send_burst(1'b1);
    wait_drain(400, ok);
    checks++; if (!ok) begin errors++; $display("FAIL sat_pos_done: got no done, want done"); end
    bx = '{0, 1}; by = '{0, -32768};
    sb.push_back(mk(16'h8000, 16'h0000, 1'b0, 1'b0));
    send_burst(1'b1);
    wait_drain(400, ok);
    checks++; if (!ok) begin errors++; $display("FAIL sat_neg_done: got no done, want done"); end
  endtask

  task automatic test_back_to_back();
    bit got, ok;
    sb.push_back(mk(16'hFF00, 16'h0400, 1'b0, 1'b1));
    sb.push_back(mk(16'h0200, 16'h0100, 1'b0, 1'b1));
    bx = '{0, 512, 1024}; by = '{1024, 512, 0};
    send_burst(1'b1);
    got = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (done) begin got = 1'b1; break; end
      @(negedge CLK);
    end
    checks++; if (!got) begin errors++; $display("FAIL b2b_first_done: got no done, want done"); end
    @(negedge CLK);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b want 1", in_ready); end
    bx = '{0, 256, 512}; by = '{256, 768, 1280};
    send_burst(1'b1);
    wait_drain(400, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_second_done: got no done, want done"); end
  endtask

  task automatic test_random();
    bit ok;
    for (int k = 0; k < 4; k++) begin
      int len;
      len = int'($urandom_range(2, 8));
      bx.delete(); by.delete();
      for (int i = 0; i < len; i++) begin
        bx.push_back(i * 256 - 1024 + int'($urandom_range(0, 63)) - 32);
        by.push_back(int'($urandom_range(0, 4095)) - 2048);
      end
      sb.push_back(model_fit());
      send_burst(1'b1);
      wait_drain(400, ok);
      checks++; if (!ok) begin errors++; $display("FAIL random_done[%0d]: got no done, want done", k); end
    end
  endtask

  task automatic test_reset_mid();
    bit seen, ok;
    bx = '{512, 768}; by = '{100, 200};
    send_burst(1'b0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midburst_busy: got %b want 1", busy); end
    RST = 1'b1; @(negedge CLK); RST = 1'b0;
    checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL midburst_reset: got in_ready=%b busy=%b, want 1/0", in_ready, busy); end
    checks++; if (slope !== 16'h0000 || intercept !== 16'h0000 || err !== 1'b0) begin errors++; $display("FAIL midburst_outputs: got %h/%h/%b want 0000/0000/0", slope, intercept, err); end
    bx = '{0, 256, 512}; by = '{256, 768, 1280};
    send_burst(1'b1);
    repeat (30) @(negedge CLK);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL middiv_busy: got %b want 1", busy); end
    RST = 1'b1; @(negedge CLK); RST = 1'b0;
    checks++; if (in_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL middiv_reset: got in_ready=%b busy=%b done=%b, want 1/0/0", in_ready, busy, done); end
    seen = 1'b0;
    repeat (250) begin
      @(negedge CLK);
      if (done) seen = 1'b1;
    end
    checks++; if (seen) begin errors++; $display("FAIL middiv_no_done: got done after abort, want none"); end
    sb.push_back(mk(16'h0200, 16'h0100, 1'b0, 1'b1));
    send_burst(1'b1);
    wait_drain(400, ok);
    checks++; if (!ok) begin errors++; $display("FAIL after_reset_done: got no done, want done"); end
  endtask

  initial begin
    test_reset();
    test_basic_fits();
    test_degenerate();
    test_hold_during_solve();
    test_max_n();
    test_saturation();
    test_back_to_back();
    test_random();
    test_reset_mid();
    repeat (2) @(negedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/lr_fit.md
Name: lr_fit

Overview:
- Streaming least-squares linear-regression engine (y = slope·x + intercept) for the LR datapath.
- Accepts a burst of signed fixed-point (x, y) samples, accumulates N, Σx, Σy, Σxy and Σx².
- On the last sample it computes slope and intercept using a closed-form solve and a sequential divider.
- Result is presented with a one-cycle done pulse.

Parameters:
- DW, 16, sample/result width (signed two's complement).
- FRAC, 8, fractional bits (Q8.8 at defaults) for x, y, slope, intercept.
- MAX_N, 256, maximum samples per burst.
- ACC_W, 64, internal accumulator/divider width (signed).

Ports:
- CLK  in  1  sole clock; all state updates on rising edge.
- RST  in  1  synchronous, active-high reset.
- in_valid  in  1  sample present.
- in_ready  out  1  high in IDLE/ACCUM; a sample transfers when in_valid&in_ready.
- in_x  in  DW  signed Q8.8 x.
- in_y  in  DW  signed Q8.8 y.
- in_last  in  1  marks final sample of burst (sampled with transfer).
- busy  out  1  high from first accepted sample until done.
- done  out  1  one-cycle pulse when slope/intercept/err are updated.
- err  out  1  degenerate fit flag (valid with done, held).
- slope  out  DW  signed Q8.8 result, held until next done.
- intercept  out  DW  signed Q8.8 result, held until next done.

Behaviour:
- Reset values:
  - All outputs 0 except in_ready=1.
  - All accumulators 0.
  - State IDLE.
  - RST mid-burst or mid-divide aborts with no done pulse.
- States and transitions:
  - IDLE: first transfer clears accumulators, adds the sample, goes to ACCUM (or directly to SOLVE if in_last).
  - ACCUM: each transfer adds the sample. A transfer with in_last, or the MAX_N-th sample (forced last), goes to SOLVE.
  - SOLVE: in_ready=0.
    - NUM = N·Σxy − Σx·Σy.
    - DEN = N·Σx² − (Σx)².
    - Dividers may be a multicycle shared multiplier.
  - DIV_S: slope = (NUM<<FRAC)/DEN.
  - CALC_B: T = Σy − ((slope·Σx) >>> FRAC).
  - DIV_B: intercept = T/N.
  - DONE: register outputs, pulse done, go to IDLE.
- Accumulation widths:
  - Products are full 2·DW signed (Q16.16).
  - All sums are sign-extended to ACC_W.
  - No wrap at defaults.
- Division: signed restoring/non-restoring, quotient truncated toward zero.
- Saturation: results are saturated to [−2^(DW−1), 2^(DW−1)−1] before output.
- Latency: last transfer → done ≤ 3·ACC_W+16 cycles; fixed for given parameters.
- Degenerate cases:
  - DEN==0 (N<2 or all x equal): err=1, slope=0, intercept=Σy/N (mean y), trunc toward zero.
  - N always ≥1 once a burst starts.
  - Otherwise err=0.
- Input flow: in_valid while in_ready=0 is ignored (not queued). The next burst may start the cycle after done.

Test Plan:
- Points (0x0000,0x0100),(0x0100,0x0300),(0x0200,0x0500), last on 3rd → done, slope=0x0200, intercept=0x0100, err=0.
- Points (0,0x0400),(0x0200,0x0200),(0x0400,0) → slope=0xFF00, intercept=0x0400, err=0.
- Points (0,0),(0x0100,0),(0x0200,0x0100) → slope=0x0080, intercept=0xFFD6 (−42/256, truncation toward zero), err=0.
- Points (0x0100,0x0200),(0x0100,0x0400) → err=1, slope=0, intercept=0x0300. Single sample (0x0500,0x0700) with in_last → err=1, slope=0, intercept=0x0700.
- Handshake/overflow:
  - in_valid held during SOLVE/DIV is ignored and in_ready=0.
  - 256 samples without in_last: forced last at the 256th sample, done fires.
  - Steep data, e.g. (0,0),(0x0001,0x7FFF): slope saturates to 0x7FFF.
- Reset mid-burst and mid-divide: assert RST one cycle → in_ready=1, busy=0, outputs 0, no done. The next burst from the first case yields slope=0x0200, intercept=0x0100.
